// File: rtl/wb_trace_checker.sv
// Write-back trace checker: compares each retired register-file write against a golden FIFO.
// Define TRACE_TIMEOUT_EN to add a RUN-state idle watchdog (err_code 3).
module wb_trace_checker #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] END_PC      = 32'h1c000100,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  output logic [1:0]  state,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] pass_cnt,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MISM  = 2'd1;
  localparam logic [1:0] ERR_UNDER = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  function automatic logic [31:0] byte_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [4:0]    wnum_mem_q  [FIFO_DEPTH];
  logic [31:0]   wdata_mem_q [FIFO_DEPTH];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pass_cnt_q, pass_cnt_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [31:0]   err_pc_q, err_pc_d, err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic          ref_ready_q, ref_ready_d, done_q, done_d;
  logic          push_s, pop_s, fail_s, wr_ev_s, match_s, tmo_hit_s;
  logic [31:0]   head_pc_s, head_wdata_s;
  logic [4:0]    head_wnum_s;

  assign push_s       = ref_valid && ref_ready_q;
  assign wr_ev_s      = (debug_wb_rf_we != 4'h0) && (debug_wb_rf_wnum != 5'd0);
  assign head_pc_s    = pc_mem_q[rd_ptr_q];
  assign head_wnum_s  = wnum_mem_q[rd_ptr_q];
  assign head_wdata_s = wdata_mem_q[rd_ptr_q];
  assign match_s      = (debug_wb_pc == head_pc_s) && (debug_wb_rf_wnum == head_wnum_s) &&
                        (((debug_wb_rf_wdata ^ head_wdata_s) & byte_mask(debug_wb_rf_we)) == 32'h0);

`ifdef TRACE_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_q, tmo_d;

  assign tmo_hit_s = (tmo_q == TMO_LAST);

  // Idle watchdog: zero outside RUN (so it is clear on entry), cleared by every write event
  always_comb begin
    tmo_d = 32'h0;
    if (state_q == ST_RUN && !wr_ev_s) begin
      tmo_d = tmo_q + 32'h1;
    end else begin
      tmo_d = 32'h0;
    end
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (reset) tmo_q <= 32'h0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state, FIFO bookkeeping and first-error capture
  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    fail_s     = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (wr_ev_s) begin
          if (count_q == '0) begin
            fail_s     = 1'b1;
            err_code_d = ERR_UNDER;
            err_exp_d  = 32'h0;
            err_got_d  = debug_wb_rf_wdata;
          end else if (match_s) begin
            pop_s      = 1'b1;
            pass_cnt_d = pass_cnt_q + 32'h1;
          end else begin
            fail_s     = 1'b1;
            err_code_d = ERR_MISM;
            err_exp_d  = head_wdata_s;
            err_got_d  = debug_wb_rf_wdata;
          end
        end else if (tmo_hit_s) begin
          fail_s     = 1'b1;
          err_code_d = ERR_TMO;
          err_exp_d  = 32'h0;
          err_got_d  = 32'h0;
        end else begin
          fail_s = 1'b0;
        end
        // A failure in the same cycle as END_PC takes precedence over PASS
        if (fail_s) begin
          state_d  = ST_FAIL;
          err_pc_d = debug_wb_pc;
        end else if (debug_wb_pc == END_PC) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PASS: state_d = ST_PASS;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase

    rd_ptr_d    = rd_ptr_q + PW'(pop_s);
    wr_ptr_d    = wr_ptr_q + PW'(push_s);
    count_d     = count_q + CW'(push_s) - CW'(pop_s);
    ref_ready_d = ((state_d == ST_IDLE) || (state_d == ST_RUN)) && (count_d < DEPTH_C);
    done_d      = (state_d == ST_PASS) || (state_d == ST_FAIL);
  end

  // Golden entry storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]    <= ref_pc;
      wnum_mem_q[wr_ptr_q]  <= ref_wnum;
      wdata_mem_q[wr_ptr_q] <= ref_wdata;
    end
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pass_cnt_q  <= 32'h0;
      err_code_q  <= ERR_NONE;
      err_pc_q    <= 32'h0;
      err_exp_q   <= 32'h0;
      err_got_q   <= 32'h0;
      ref_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pass_cnt_q  <= pass_cnt_d;
      err_code_q  <= err_code_d;
      err_pc_q    <= err_pc_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
      ref_ready_q <= ref_ready_d;
      done_q      <= done_d;
    end
  end

  assign ref_ready     = ref_ready_q;
  assign state         = state_q;
  assign done          = done_q;
  assign err_code      = err_code_q;
  assign pass_cnt      = pass_cnt_q;
  assign err_pc        = err_pc_q;
  assign err_exp_wdata = err_exp_q;
  assign err_got_wdata = err_got_q;

endmodule
